// File: rtl/mem_tcp_send.sv
// mem_tcp_send: streams per-session memory regions to a TCP stack as segments.
// Optional MEM_TCP_SEND_STAT_EN builds the segment/beat counters on status_reg.
module mem_tcp_send #(
  parameter int SESSION_SIZE    = 32*1024*1024,
  parameter int MAX_SESSION_NUM = 16,
  parameter int MAX_PKG_LEN     = 1024,
  parameter int RETRY_WAIT      = 1000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                s_axis_send_req_valid,
  output logic                s_axis_send_req_ready,
  input  logic [31:0]         s_axis_send_req_data,
  output logic                m_axis_ddr_read_cmd_valid,
  input  logic                m_axis_ddr_read_cmd_ready,
  output logic [63:0]         m_axis_ddr_read_cmd_address,
  output logic [31:0]         m_axis_ddr_read_cmd_length,
  input  logic                s_axis_ddr_read_data_valid,
  output logic                s_axis_ddr_read_data_ready,
  input  logic [511:0]        s_axis_ddr_read_data_data,
  input  logic [63:0]         s_axis_ddr_read_data_keep,
  input  logic                s_axis_ddr_read_data_last,
  output logic                m_axis_tx_metadata_valid,
  input  logic                m_axis_tx_metadata_ready,
  output logic [31:0]         m_axis_tx_metadata_data,
  input  logic                s_axis_tx_status_valid,
  output logic                s_axis_tx_status_ready,
  input  logic [63:0]         s_axis_tx_status_data,
  output logic                m_axis_tx_data_valid,
  input  logic                m_axis_tx_data_ready,
  output logic [511:0]        m_axis_tx_data_data,
  output logic [63:0]         m_axis_tx_data_keep,
  output logic                m_axis_tx_data_last,
  output logic [1:0][31:0]    status_reg
);

  localparam int IW = (MAX_SESSION_NUM > 1) ? $clog2(MAX_SESSION_NUM) : 1;
  localparam logic [15:0] PKG  = 16'(MAX_PKG_LEN);
  localparam logic [32:0] SS33 = 33'(SESSION_SIZE);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_FETCH       = 3'd1;
  localparam logic [2:0] S_TX_META     = 3'd2;
  localparam logic [2:0] S_WAIT_STATUS = 3'd3;
  localparam logic [2:0] S_RETRY       = 3'd4;
  localparam logic [2:0] S_READ_CMD    = 3'd5;
  localparam logic [2:0] S_TX_DATA     = 3'd6;
  localparam logic [2:0] S_NEXT        = 3'd7;

  logic [31:0]  fifo_mem [16];
  logic [3:0]   wptr, rptr;
  logic [4:0]   count;
  logic         run;
  logic         push, pop;

  logic [2:0]   state;
  logic [31:0]  req_q;
  logic [15:0]  remaining, sess, seg_len;
  logic [31:0]  retry_cnt;
  logic [10:0]  in_cnt, out_cnt, beats;
  logic         slice_valid;
  logic [511:0] slice_data;
  logic [31:0]  rd_ptr [MAX_SESSION_NUM];

  logic [IW-1:0] idx;
  logic [31:0]   ptr_cur, ptr_next;
  logic [32:0]   ptr_sum, ptr_wrap;
  logic          status_fire, status_ok;
  logic          in_fire, out_fire;
  logic [5:0]    tail;

  // ready is held low for the first cycle out of reset
  assign s_axis_send_req_ready = run && (count < 5'd14);
  assign push = s_axis_send_req_valid && s_axis_send_req_ready;
  assign pop  = (state == S_IDLE) && (count != 5'd0);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= s_axis_send_req_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      run   <= 1'b0;
    end else begin
      run   <= 1'b1;
      if (push) wptr <= wptr + 4'd1;
      if (pop) rptr <= rptr + 4'd1;
      count <= count + 5'(push) - 5'(pop);
    end
  end

  assign seg_len = (remaining > PKG) ? PKG : remaining;
  assign beats   = {1'b0, seg_len[15:6]} + 11'(|seg_len[5:0]);
  assign tail    = seg_len[5:0];

  assign idx      = sess[IW-1:0];
  assign ptr_cur  = rd_ptr[idx];
  assign ptr_sum  = {1'b0, ptr_cur} + {17'b0, seg_len};
  assign ptr_wrap = ptr_sum - SS33;
  assign ptr_next = (ptr_sum >= SS33) ? ptr_wrap[31:0] : ptr_sum[31:0];

  assign m_axis_tx_metadata_valid = (state == S_TX_META);
  assign m_axis_tx_metadata_data  = {seg_len, sess};

  assign s_axis_tx_status_ready = (state == S_WAIT_STATUS);
  assign status_fire = s_axis_tx_status_ready && s_axis_tx_status_valid;
  // a status for another session is as good as a refusal
  assign status_ok   = (s_axis_tx_status_data[63:62] == 2'b00) &&
                       (s_axis_tx_status_data[15:0] == sess);

  assign m_axis_ddr_read_cmd_valid   = (state == S_READ_CMD);
  assign m_axis_ddr_read_cmd_address = 64'(SESSION_SIZE) * 64'(idx) +
                                       {32'b0, ptr_cur};
  assign m_axis_ddr_read_cmd_length  = {16'b0, seg_len};

  assign s_axis_ddr_read_data_ready = (state == S_TX_DATA) &&
                                      (in_cnt != beats) &&
                                      (!slice_valid || m_axis_tx_data_ready);
  assign in_fire  = s_axis_ddr_read_data_ready && s_axis_ddr_read_data_valid;

  assign m_axis_tx_data_valid = slice_valid && (state == S_TX_DATA);
  assign m_axis_tx_data_data  = slice_data;
  assign m_axis_tx_data_last  = (out_cnt == beats - 11'd1);
  assign m_axis_tx_data_keep  = (m_axis_tx_data_last && tail != 6'd0) ?
                                ~({64{1'b1}} << tail) : {64{1'b1}};
  assign out_fire = m_axis_tx_data_valid && m_axis_tx_data_ready;

  always_ff @(posedge clk) begin
    if (in_fire) slice_data <= s_axis_ddr_read_data_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      req_q       <= '0;
      remaining   <= '0;
      sess        <= '0;
      retry_cnt   <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      slice_valid <= 1'b0;
      for (int i = 0; i < MAX_SESSION_NUM; i++) rd_ptr[i] <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (pop) begin
            req_q <= fifo_mem[rptr];
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          remaining <= req_q[31:16];
          sess      <= req_q[15:0];
          state     <= (req_q[31:16] == 16'd0) ? S_IDLE : S_TX_META;
        end
        S_TX_META: begin
          if (m_axis_tx_metadata_ready) state <= S_WAIT_STATUS;
        end
        S_WAIT_STATUS: begin
          if (status_fire) begin
            retry_cnt <= '0;
            state     <= status_ok ? S_READ_CMD : S_RETRY;
          end
        end
        S_RETRY: begin
          retry_cnt <= retry_cnt + 32'd1;
          if (retry_cnt + 32'd1 >= 32'(RETRY_WAIT)) state <= S_TX_META;
        end
        S_READ_CMD: begin
          if (m_axis_ddr_read_cmd_ready) begin
            rd_ptr[idx] <= ptr_next;
            in_cnt      <= '0;
            out_cnt     <= '0;
            state       <= S_TX_DATA;
          end
        end
        S_TX_DATA: begin
          if (in_fire) slice_valid <= 1'b1;
          else if (out_fire) slice_valid <= 1'b0;
          in_cnt  <= in_cnt + 11'(in_fire);
          out_cnt <= out_cnt + 11'(out_fire);
          if (out_fire && m_axis_tx_data_last) begin
            slice_valid <= 1'b0;
            remaining   <= remaining - seg_len;
            state       <= S_NEXT;
          end
        end
        S_NEXT: state <= (remaining != 16'd0) ? S_TX_META : S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_TCP_SEND_STAT_EN
  logic [31:0] seg_cnt, beat_cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      seg_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      if (status_fire && status_ok) seg_cnt <= seg_cnt + 32'd1;
      if (out_fire) beat_cnt <= beat_cnt + 32'd1;
    end
  end

  assign status_reg[0] = seg_cnt;
  assign status_reg[1] = beat_cnt;
`else
  assign status_reg = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{s_axis_tx_status_data[61:16],
                       s_axis_ddr_read_data_keep,
                       s_axis_ddr_read_data_last,
                       ptr_wrap[32]};

endmodule
